// File: rtl/washing_machine.sv
// Front-loader sequencing controller: door check, soap wash, rinse, spin, done pulse.
// Moore FSM; the rinse flag selects which pass FILL/WASH/DRAIN belong to.
module washing_machine (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic door_close,
    input  logic filled,
    input  logic detergent_added,
    input  logic drained,
    input  logic spin_time_out,
    input  logic cycle_time_out,
    output logic door_lock,
    output logic fill_valve_on,
    output logic motor_on,
    output logic drain_valve_on,
    output logic done,
    output logic soap_wash,
    output logic water_wash
);

    typedef enum logic [2:0] {
        S_CHECK_DOOR = 3'd0,
        S_FILL       = 3'd1,
        S_DETERGENT  = 3'd2,
        S_WASH       = 3'd3,
        S_DRAIN      = 3'd4,
        S_SPIN       = 3'd5,
        S_DONE       = 3'd6
    } state_e;

    state_e state_q, state_d;
    logic   rinse_q, rinse_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_CHECK_DOOR;
            rinse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rinse_q <= rinse_d;
        end
    end

    // Only the current state's exit condition is looked at; everything else holds.
    always_comb begin
        state_d = state_q;
        rinse_d = rinse_q;
        unique case (state_q)
            S_CHECK_DOOR: begin
                if (start && door_close) begin
                    state_d = S_FILL;
                    rinse_d = 1'b0;
                end
            end
            S_FILL: begin
                if (filled) state_d = rinse_q ? S_WASH : S_DETERGENT;
            end
            S_DETERGENT: begin
                if (detergent_added) state_d = S_WASH;
            end
            S_WASH: begin
                if (cycle_time_out) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (drained) begin
                    if (rinse_q) begin
                        state_d = S_SPIN;
                    end else begin
                        state_d = S_FILL;
                        rinse_d = 1'b1;
                    end
                end
            end
            S_SPIN: begin
                if (spin_time_out) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_CHECK_DOOR;
            end
            default: begin
                state_d = S_CHECK_DOOR;
                rinse_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        door_lock      = 1'b0;
        fill_valve_on  = 1'b0;
        motor_on       = 1'b0;
        drain_valve_on = 1'b0;
        done           = 1'b0;
        soap_wash      = 1'b0;
        water_wash     = 1'b0;
        unique case (state_q)
            S_CHECK_DOOR: ;
            S_FILL: begin
                door_lock     = 1'b1;
                fill_valve_on = 1'b1;
                water_wash    = rinse_q;
            end
            S_DETERGENT: begin
                door_lock = 1'b1;
                soap_wash = 1'b1;
            end
            S_WASH: begin
                door_lock  = 1'b1;
                motor_on   = 1'b1;
                soap_wash  = !rinse_q;
                water_wash = rinse_q;
            end
            S_DRAIN: begin
                door_lock      = 1'b1;
                drain_valve_on = 1'b1;
                soap_wash      = !rinse_q;
                water_wash     = rinse_q;
            end
            S_SPIN: begin
                door_lock      = 1'b1;
                motor_on       = 1'b1;
                drain_valve_on = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_washing_machine.sv
// Bench for washing_machine: fixed vector table, hand sequences for corner cases,
// and random stimulus checked against a linear step-list model of a full cycle.
module tb_washing_machine;

    logic clk = 1'b0;
    logic reset;
    logic start, door_close, filled, detergent_added, drained, spin_time_out, cycle_time_out;
    logic door_lock, fill_valve_on, motor_on, drain_valve_on, done, soap_wash, water_wash;
    logic [6:0] outs;

    int n_total = 0;
    int n_pass  = 0;

    washing_machine dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .door_close     (door_close),
        .filled         (filled),
        .detergent_added(detergent_added),
        .drained        (drained),
        .spin_time_out  (spin_time_out),
        .cycle_time_out (cycle_time_out),
        .door_lock      (door_lock),
        .fill_valve_on  (fill_valve_on),
        .motor_on       (motor_on),
        .drain_valve_on (drain_valve_on),
        .done           (done),
        .soap_wash      (soap_wash),
        .water_wash     (water_wash)
    );

    always #5 clk = ~clk;

    // {door_lock, fill_valve_on, motor_on, drain_valve_on, done, soap_wash, water_wash}
    assign outs = {door_lock, fill_valve_on, motor_on, drain_valve_on, done, soap_wash, water_wash};

    // Inputs packed as {start, door_close, filled, detergent_added, drained, spin_time_out, cycle_time_out}
    localparam logic [6:0] I_NONE  = 7'b0000000;
    localparam logic [6:0] I_DOOR  = 7'b0100000;
    localparam logic [6:0] I_START = 7'b1000000;
    localparam logic [6:0] I_GO    = 7'b1100000;
    localparam logic [6:0] I_FILL  = 7'b0010000;
    localparam logic [6:0] I_DET   = 7'b0001000;
    localparam logic [6:0] I_DRN   = 7'b0000100;
    localparam logic [6:0] I_SPIN  = 7'b0000010;
    localparam logic [6:0] I_CTO   = 7'b0000001;

    localparam logic [6:0] O_IDLE  = 7'b0000000;
    localparam logic [6:0] O_FILL1 = 7'b1100000;
    localparam logic [6:0] O_DET   = 7'b1000010;
    localparam logic [6:0] O_WASH1 = 7'b1010010;
    localparam logic [6:0] O_DRN1  = 7'b1001010;
    localparam logic [6:0] O_FILL2 = 7'b1100001;
    localparam logic [6:0] O_WASH2 = 7'b1010001;
    localparam logic [6:0] O_DRN2  = 7'b1001001;
    localparam logic [6:0] O_SPIN  = 7'b1011000;
    localparam logic [6:0] O_DONE  = 7'b0000100;

    typedef struct {
        logic [6:0] in;
        logic [6:0] exp;
        string      name;
    } vec_t;

    // Reference: a full cycle is a fixed list of ten steps, each with its
    // output pattern and the one input that advances it.
    logic [6:0] step_out [10];
    int         pos;

    function automatic bit step_advances(int p, logic [6:0] in);
        case (p)
            0:       return in[6] & in[5];
            1, 5:    return in[4];
            2:       return in[3];
            3, 6:    return in[0];
            4, 7:    return in[2];
            8:       return in[1];
            default: return 1'b1;
        endcase
    endfunction

    task automatic check(input string name, input logic [6:0] exp);
        n_total++;
        if (outs === exp) n_pass++;
        else $display("FAIL %s: outputs got %b expected %b", name, outs, exp);
    endtask

    task automatic drive(input logic [6:0] in);
        {start, door_close, filled, detergent_added, drained, spin_time_out, cycle_time_out} = in;
    endtask

    // Drive inputs, take one rising edge, sample 1 time unit later.
    task automatic apply(input logic [6:0] in, input logic [6:0] exp, input string name);
        drive(in);
        @(posedge clk);
        #1;
        check(name, exp);
    endtask

    task automatic async_reset_pulse(input logic [6:0] exp_during, input string name);
        #3 reset = 1'b1;
        #1 check(name, exp_during);
        #1 reset = 1'b0;
    endtask

    vec_t tbl [$];

    initial begin
        step_out[0] = O_IDLE;  step_out[1] = O_FILL1; step_out[2] = O_DET;
        step_out[3] = O_WASH1; step_out[4] = O_DRN1;  step_out[5] = O_FILL2;
        step_out[6] = O_WASH2; step_out[7] = O_DRN2;  step_out[8] = O_SPIN;
        step_out[9] = O_DONE;

        tbl.push_back('{I_DOOR,  O_IDLE,  "idle_no_start"});
        for (int i = 0; i < 5; i++) tbl.push_back('{I_START, O_IDLE, "start_door_open"});
        tbl.push_back('{I_GO,    O_FILL1, "enter_fill"});
        tbl.push_back('{I_NONE,  O_FILL1, "fill_hold_start_dropped"});
        tbl.push_back('{I_FILL,  O_DET,   "detergent"});
        tbl.push_back('{I_DET,   O_WASH1, "wash_soap"});
        tbl.push_back('{I_CTO,   O_DRN1,  "drain_soap"});
        tbl.push_back('{I_DRN,   O_FILL2, "fill_rinse"});
        tbl.push_back('{I_FILL,  O_WASH2, "wash_rinse"});
        tbl.push_back('{I_CTO,   O_DRN2,  "drain_rinse"});
        tbl.push_back('{I_DRN,   O_SPIN,  "spin"});
        tbl.push_back('{I_SPIN,  O_DONE,  "done_pulse"});
        tbl.push_back('{I_NONE,  O_IDLE,  "after_done"});
        tbl.push_back('{I_NONE,  O_IDLE,  "idle_stays"});

        reset = 1'b1;
        drive(I_NONE);
        repeat (2) @(posedge clk);
        #1 check("reset_held", O_IDLE);
        reset = 1'b0;

        foreach (tbl[i]) apply(tbl[i].in, tbl[i].exp, tbl[i].name);

        // WASH ignores door/start drop and stray sensors.
        apply(I_GO,   O_FILL1, "seqA_fill");
        apply(I_FILL, O_DET,   "seqA_det");
        apply(I_DET,  O_WASH1, "seqA_wash");
        apply(I_FILL | I_DRN,          O_WASH1, "wash_ignore_fill_drained");
        apply(I_FILL | I_DRN | I_SPIN, O_WASH1, "wash_ignore_spin");
        apply(I_DET,  O_WASH1, "wash_ignore_det");
        apply(I_CTO,  O_DRN1,  "seqA_drain1");
        apply(I_DRN,  O_FILL2, "seqA_fill2");
        apply(I_FILL, O_WASH2, "seqA_wash2");
        apply(I_CTO,  O_DRN2,  "seqA_drain2");
        apply(I_DRN,  O_SPIN,  "seqA_spin");

        async_reset_pulse(O_IDLE, "async_reset_mid_spin");
        apply(I_GO,   O_FILL1, "post_reset_fill");
        apply(I_GO | I_FILL, O_DET, "post_reset_soap_path");

        // start/door held high through DONE restarts the soap path.
        apply(I_GO | I_DET,  O_WASH1, "held_wash1");
        apply(I_GO | I_CTO,  O_DRN1,  "held_drain1");
        apply(I_GO | I_DRN,  O_FILL2, "held_fill2");
        apply(I_GO | I_FILL, O_WASH2, "held_wash2");
        apply(I_GO | I_CTO,  O_DRN2,  "held_drain2");
        apply(I_GO | I_DRN,  O_SPIN,  "held_spin");
        apply(I_GO | I_SPIN, O_DONE,  "held_done");
        apply(I_GO,          O_IDLE,  "held_check_door");
        apply(I_GO,          O_FILL1, "held_refill");
        apply(I_GO | I_FILL, O_DET,   "held_soap_again");

        // Random run against the step-list model.
        async_reset_pulse(O_IDLE, "rand_start_reset");
        pos = 0;
        for (int i = 0; i < 600; i++) begin
            logic [6:0] in;
            in[6] = ($urandom_range(0, 1) == 1);
            in[5] = ($urandom_range(0, 1) == 1);
            for (int b = 0; b < 5; b++) in[b] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 79) == 0) begin
                async_reset_pulse(O_IDLE, "rand_async_reset");
                pos = 0;
            end
            if (step_advances(pos, in)) pos = (pos + 1) % 10;
            apply(in, step_out[pos], $sformatf("rand_%0d_step%0d", i, pos));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
